// File: rtl/yubex_edge_rate_meter_pkg.sv
// Shared definitions for the edge-rate meter and later display blocks:
// FSM state codes, the dash pattern and the hex-digit segment table.
package yubex_edge_rate_meter_pkg;

    typedef enum logic {
        ST_ARM  = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    // Segments a..g on bits 0..6, active-high
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Index n holds the pattern for hex digit n (entry 15 first)
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Look up the 7-segment pattern of one hex digit
    function automatic logic [6:0] hex_seg(input logic [3:0] val);
        return SEG_HEX[val];
    endfunction

endpackage

// File: rtl/yubex_edge_rate_meter_hex_to_7seg.sv
// Hex digit to 7-segment pattern, purely combinational.
module yubex_edge_rate_meter_hex_to_7seg
    import yubex_edge_rate_meter_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg_c
);

    assign o_seg_c = hex_seg(i_val);

endmodule

// File: rtl/yubex_edge_rate_meter.sv
// Edge-rate meter: counts the selected edge pulses over a fixed gate window
// and shows the latched count as one hex digit; dp flags a saturated count.
module yubex_edge_rate_meter
    import yubex_edge_rate_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 12500,
    parameter int unsigned CNT_WIDTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rise_pulse,
    input  logic       fall_pulse,
    input  logic       edge_sel,
    input  logic       hold,
    output logic [6:0] seg,
    output logic       dp,
    output logic       window_tick
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]    GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    logic [GATE_W-1:0]    r_gate_cnt;
    logic [CNT_WIDTH-1:0] r_edge_cnt;
    logic [CNT_WIDTH-1:0] r_disp_val;
    logic                 r_disp_ovf;
    state_e               r_state;
    logic                 r_edge_sel_q;
    logic                 r_sel_valid;
    logic [6:0]           r_seg;
    logic                 r_dp;

    logic                 w_sel_chg;
    logic                 w_gate_last;
    logic                 w_tick;
    logic                 w_pulse;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [6:0]           w_hex_seg;

    // A selection change only counts once the registered copy holds a real sample
    assign w_sel_chg   = r_sel_valid & (edge_sel != r_edge_sel_q);
    assign w_gate_last = (r_gate_cnt == GATE_LAST);
    assign w_tick      = w_gate_last & ~w_sel_chg;
    assign window_tick = w_tick;

    // Selected pulse for this cycle; the unselected one is ignored
    assign w_pulse    = edge_sel ? fall_pulse : rise_pulse;
    assign w_cnt_next = (w_pulse && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + CNT_WIDTH'(1)
                                                             : r_edge_cnt;

    // Registered copy of edge_sel, first sampled on the clock after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_sel_q <= 1'b0;
            r_sel_valid  <= 1'b0;
        end else begin
            r_edge_sel_q <= edge_sel;
            r_sel_valid  <= 1'b1;
        end
    end

    // Gate counter and saturating edge counter; both restart on a selection change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
        end else if (w_sel_chg) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
        end else if (w_gate_last) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
            r_edge_cnt <= w_cnt_next;
        end
    end

    // ARM/SHOW state and display latch; hold freezes the latch but not counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_ARM;
            r_disp_val <= '0;
            r_disp_ovf <= 1'b0;
        end else if (w_sel_chg) begin
            r_state <= ST_ARM;
        end else if (w_tick && !hold) begin
            r_state    <= ST_SHOW;
            r_disp_val <= w_cnt_next;
            r_disp_ovf <= (w_cnt_next == CNT_MAX);
        end
    end

    yubex_edge_rate_meter_hex_to_7seg u_hex (
        .i_val   (4'(r_disp_val)),
        .o_seg_c (w_hex_seg)
    );

    // Output registers: digit in SHOW, dash while no valid result exists
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_DASH;
            r_dp  <= 1'b0;
        end else begin
            r_seg <= (r_state == ST_SHOW) ? w_hex_seg : SEG_DASH;
            r_dp  <= r_disp_ovf & (r_state == ST_SHOW);
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_yubex_edge_rate_meter.sv
// Bench for yubex_edge_rate_meter with a 16-cycle gate window.
module tb_yubex_edge_rate_meter;

    localparam int unsigned G = 16;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       edge_sel;
    logic       hold;
    logic [6:0] seg;
    logic       dp;
    logic       window_tick;

    always #5 clk = ~clk;

    yubex_edge_rate_meter #(
        .GATE_CYCLES (G),
        .CNT_WIDTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .edge_sel    (edge_sel),
        .hold        (hold),
        .seg         (seg),
        .dp          (dp),
        .window_tick (window_tick)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: window position, raw (unbounded) count, shown result
    int         m_pos;
    int         m_count;
    int         m_disp;
    int         m_sel_prev;
    bit         m_valid;
    logic [6:0] m_seg;
    bit         m_dp;
    logic       last_tick;

    typedef struct {
        int         nr;
        int         nf;
        bit         sel;
        bit         hold;
        logic [6:0] eseg;
        bit         edp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos      = 0;
        m_count    = 0;
        m_disp     = 0;
        m_valid    = 1'b0;
        m_sel_prev = -1;
        m_seg      = 7'h40;
        m_dp       = 1'b0;
    endtask

    // One clock: drive at negedge, check tick before posedge, check display after
    task automatic step(input bit r, input bit f, input bit s, input bit h);
        bit         chg;
        bit         tick;
        int         cnt;
        logic [6:0] nseg;
        bit         ndp;
        rise_pulse = r;
        fall_pulse = f;
        edge_sel   = s;
        hold       = h;
        #1;
        chg  = (m_sel_prev >= 0) && (int'(s) != m_sel_prev);
        tick = !chg && (m_pos == G - 1);
        last_tick = window_tick;
        chk("window_tick", 32'(window_tick), 32'(tick));
        @(posedge clk);
        nseg = m_valid ? HEX[m_disp] : 7'h40;
        ndp  = m_valid && (m_disp == 15);
        if (chg) begin
            m_pos   = 0;
            m_count = 0;
            m_valid = 1'b0;
        end else begin
            cnt = m_count + ((s ? f : r) ? 1 : 0);
            if (tick) begin
                if (!h) begin
                    m_disp  = (cnt > 15) ? 15 : cnt;
                    m_valid = 1'b1;
                end
                m_count = 0;
            end else begin
                m_count = cnt;
            end
            m_pos = (m_pos + 1) % G;
        end
        m_sel_prev = int'(s);
        m_seg      = nseg;
        m_dp       = ndp;
        @(negedge clk);
        chk("seg", 32'(seg), 32'(m_seg));
        chk("dp", 32'(dp), 32'(m_dp));
    endtask

    // One full window from position 0; restart first if selection changes.
    // The previous record's display is checked on the first clock.
    task automatic run_window(input int idx, input vec_t v, input bit chk_prev,
                              input logic [6:0] pseg, input bit pdp);
        bit pending;
        pending = chk_prev;
        if (m_sel_prev >= 0 && int'(v.sel) != m_sel_prev) begin
            step(1'b0, 1'b0, v.sel, v.hold);
            if (pending) begin
                chk($sformatf("vec%0d_seg", idx - 1), 32'(seg), 32'(pseg));
                chk($sformatf("vec%0d_dp", idx - 1), 32'(dp), 32'(pdp));
                pending = 1'b0;
            end
        end
        for (int c = 0; c < int'(G); c++) begin
            step(c >= int'(G) - v.nr, c < v.nf, v.sel, v.hold);
            if (c == 0 && pending) begin
                chk($sformatf("vec%0d_seg", idx - 1), 32'(seg), 32'(pseg));
                chk($sformatf("vec%0d_dp", idx - 1), 32'(dp), 32'(pdp));
            end
        end
    endtask

    task automatic align(input int target);
        for (int k = 0; k < int'(G) && m_pos != target; k++)
            step(1'b0, 1'b0, edge_sel, 1'b0);
    endtask

    initial begin
        vec_t flush;
        bit   s;
        bit   h;

        tbl[0] = '{5,  3,  1'b0, 1'b0, 7'h6D, 1'b0};
        tbl[1] = '{5,  3,  1'b1, 1'b0, 7'h4F, 1'b0};
        tbl[2] = '{16, 0,  1'b0, 1'b0, 7'h71, 1'b1};
        tbl[3] = '{2,  5,  1'b0, 1'b0, 7'h5B, 1'b0};
        tbl[4] = '{7,  16, 1'b0, 1'b0, 7'h07, 1'b0};
        tbl[5] = '{4,  0,  1'b0, 1'b1, 7'h07, 1'b0};
        tbl[6] = '{9,  2,  1'b0, 1'b0, 7'h6F, 1'b0};
        tbl[7] = '{0,  0,  1'b0, 1'b0, 7'h3F, 1'b0};
        tbl[8] = '{5,  3,  1'b1, 1'b1, 7'h40, 1'b0};
        tbl[9] = '{3,  14, 1'b1, 1'b0, 7'h79, 1'b0};

        rst        = 1'b1;
        rise_pulse = 1'b0;
        fall_pulse = 1'b0;
        edge_sel   = 1'b0;
        hold       = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h40);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_tick", 32'(window_tick), 32'h0);
        rst = 1'b0;

        // Idle windows: dash until the first result, then 0
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 15) begin
                chk("t1_tick_first", 32'(last_tick), 32'h1);
                chk("t1_dash_at_tick", 32'(seg), 32'h40);
            end
            if (k == 16) chk("t1_zero", 32'(seg), 32'h3F);
            if (k == 31) chk("t1_tick_second", 32'(last_tick), 32'h1);
        end
        align(0);

        for (int i = 0; i < 10; i++)
            run_window(i, tbl[i], i > 0, tbl[(i > 0) ? i - 1 : 0].eseg,
                       tbl[(i > 0) ? i - 1 : 0].edp);
        flush = '{0, 0, tbl[9].sel, 1'b0, 7'h40, 1'b0};
        run_window(10, flush, 1'b1, tbl[9].eseg, tbl[9].edp);

        // Mid-window selection toggle restarts the gate and drops back to dash
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_chg_no_tick", 32'(last_tick), 32'h0);
        for (int k = 0; k < 16; k++) begin
            step(k >= 3 && k <= 5, 1'b0, 1'b0, 1'b0);
            if (k == 0) chk("t6_dash", 32'(seg), 32'h40);
            if (k < 15 && last_tick) chk("t6_early_tick", 32'(last_tick), 32'h0);
            if (k == 15) chk("t6_tick_gap", 32'(last_tick), 32'h1);
        end
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_shown", 32'(seg), 32'h4F);

        // Asynchronous reset mid-window clears display immediately
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_seg", 32'(seg), 32'h40);
        chk("t6_rst_dp", 32'(dp), 32'h0);
        chk("t6_rst_tick", 32'(window_tick), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (k == 15) chk("t6_tick_after_rst", 32'(last_tick), 32'h1);
        end

        // A selection change on the last window cycle wins over the tick
        align(G - 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_chg_prio", 32'(last_tick), 32'h0);

        // Randomized traffic against the model
        s = 1'b0;
        h = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 49) == 0) s = ~s;
            if ($urandom_range(0, 19) == 0) h = ~h;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s, h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
